pattern_sequencer: RTL and testbench

Controller that drives the synthetic image generator's pattern_select and frame_counter inputs. It counts frames from the video timing pixel position and auto-cycles test patterns, or lets the user step patterns manually with a push button. All pattern changes are applied only at end of frame, so no frame shows two patterns. It sits between the video timing block and the image generator, alongside the convolution test path.

---
 rtl/pattern_pkg.sv | 24 ++
 rtl/pattern_sequencer_button_debounce.sv | 55 +++++
 rtl/pattern_sequencer.sv | 152 +++++++++++++++
 tb/tb_pattern_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern path: pattern indices used by both
// the image generator and the sequencer, the sequencer state encoding and the
// common bus widths.
package pattern_pkg;

    localparam int PAT_W       = 2;
    localparam int FRAME_CNT_W = 16;

    localparam logic [PAT_W-1:0] PAT_CHECKERBOARD = 2'd0;
    localparam logic [PAT_W-1:0] PAT_GRADIENT     = 2'd1;
    localparam logic [PAT_W-1:0] PAT_GEOMETRIC    = 2'd2;
    localparam logic [PAT_W-1:0] PAT_STRIPES      = 2'd3;

    typedef enum logic {
        S_AUTO   = 1'b0,
        S_MANUAL = 1'b1
    } seq_state_t;

    // Next pattern index; the 2-bit index wraps from the last pattern to the first.
    function automatic logic [PAT_W-1:0] next_pattern(input logic [PAT_W-1:0] pat);
        return pat + 2'd1;
    endfunction

endpackage

// File: rtl/pattern_sequencer_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level filter and a
// one-cycle pulse on each accepted press. Releases produce no pulse.
module button_debounce
    import pattern_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    // The counter value climbs while the synchronised input disagrees with the
    // stable level; the level flips on the edge where it reaches DEBOUNCE_CYCLES-1,
    // so the largest value actually held in the register is DEBOUNCE_CYCLES-2.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       sync_r;
    logic             level_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchronise the raw button, filter it to a stable level and pulse on its rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r    <= 2'b00;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            cnt_r     <= '0;
            press_r   <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], btn_raw};
            level_d_r <= level_r;
            press_r   <= level_r & ~level_d_r;
            if (sync_r[1] != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync_r[1];
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/pattern_sequencer.sv
// Drives pattern_select and frame_counter of the synthetic image generator.
// Frames are counted from the pixel position; patterns either auto-cycle after
// a fixed dwell or step on a debounced button. Every pattern change lands on
// the edge after the end-of-frame pulse, so no frame mixes two patterns.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE           = 640,
    parameter int V_ACTIVE           = 480,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int FRAME_STEP         = 64,
    parameter int DEBOUNCE_CYCLES    = 250000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    input  logic                   pixel_valid,
    input  logic                   btn_next,
    input  logic                   btn_mode,
    output logic [PAT_W-1:0]       pattern_select,
    output logic [FRAME_CNT_W-1:0] frame_counter,
    output logic                   auto_mode,
    output logic                   pattern_changed,
    output logic                   frame_tick
);

    localparam int DWELL_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [DWELL_W-1:0]     DWELL_LAST = DWELL_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [9:0]             X_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [9:0]             Y_LAST     = 10'(V_ACTIVE - 1);
    localparam logic [FRAME_CNT_W-1:0] STEP       = FRAME_CNT_W'(FRAME_STEP);

    logic                   eof_cond_s;
    logic                   eof_d_r;
    logic                   frame_tick_r;
    logic [FRAME_CNT_W-1:0] frame_counter_r;
    seq_state_t             state_r;
    logic [DWELL_W-1:0]     dwell_r;
    logic                   pending_r;
    logic [PAT_W-1:0]       pattern_r;
    logic                   changed_r;
    logic                   mode_press_s;
    logic                   next_press_s;
    logic                   mode_level_unused_s;
    logic                   next_level_unused_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_mode),
        .level   (mode_level_unused_s),
        .press   (mode_press_s)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_next),
        .level   (next_level_unused_s),
        .press   (next_press_s)
    );

    assign eof_cond_s = pixel_valid & (pixel_x == X_LAST) & (pixel_y == Y_LAST);

    // End-of-frame detect: one pulse on the first cycle of the last pixel, even if it is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eof_d_r      <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            eof_d_r      <= eof_cond_s;
            frame_tick_r <= eof_cond_s & ~eof_d_r;
        end
    end

    // Animation counter: advances by FRAME_STEP once per frame, wrapping silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_counter_r <= '0;
        end else if (frame_tick_r) begin
            frame_counter_r <= frame_counter_r + STEP;
        end else begin
            frame_counter_r <= frame_counter_r;
        end
    end

    // Mode/step controller: a mode press always wins and suppresses the frame action of the old state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_AUTO;
            dwell_r   <= '0;
            pending_r <= 1'b0;
            pattern_r <= PAT_CHECKERBOARD;
            changed_r <= 1'b0;
        end else begin
            changed_r <= 1'b0;
            if (mode_press_s) begin
                case (state_r)
                    S_AUTO: begin
                        state_r   <= S_MANUAL;
                        pending_r <= 1'b0;
                    end
                    S_MANUAL: begin
                        state_r <= S_AUTO;
                        dwell_r <= '0;
                    end
                    default: begin
                        state_r   <= S_AUTO;
                        dwell_r   <= '0;
                        pending_r <= 1'b0;
                    end
                endcase
            end else begin
                case (state_r)
                    S_AUTO: begin
                        if (frame_tick_r) begin
                            if (dwell_r == DWELL_LAST) begin
                                dwell_r   <= '0;
                                pattern_r <= next_pattern(pattern_r);
                                changed_r <= 1'b1;
                            end else begin
                                dwell_r <= dwell_r + DWELL_W'(1);
                            end
                        end
                    end
                    S_MANUAL: begin
                        if (frame_tick_r && pending_r) begin
                            pattern_r <= next_pattern(pattern_r);
                            pending_r <= 1'b0;
                            changed_r <= 1'b1;
                        end
                        // A press on the tick cycle is kept for the following frame.
                        if (next_press_s) begin
                            pending_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= S_AUTO;
                    end
                endcase
            end
        end
    end

    assign pattern_select  = pattern_r;
    assign frame_counter   = frame_counter_r;
    assign auto_mode       = (state_r == S_AUTO);
    assign pattern_changed = changed_r;
    assign frame_tick      = frame_tick_r;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer with a small 8x4 frame and a short
// debounce. Stimulus pushes the expected state seen at each frame_tick and the
// expected new pattern for each pattern_changed; a monitor pops and compares.
module tb_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic        btn_next;
    logic        btn_mode;
    logic [1:0]  pattern_select;
    logic [15:0] frame_counter;
    logic        auto_mode;
    logic        pattern_changed;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int n_chg = 0;

    logic [18:0] tick_q[$];
    logic [1:0]  chg_q[$];
    logic [18:0] tick_e;
    logic [1:0]  chg_e;

    logic [15:0] exp_fc;
    logic [1:0]  exp_pat;
    logic        exp_auto;
    logic [15:0] n_fast;

    pattern_sequencer #(
        .H_ACTIVE(8), .V_ACTIVE(4), .FRAMES_PER_PATTERN(3),
        .FRAME_STEP(64), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .pixel_valid     (pixel_valid),
        .btn_next        (btn_next),
        .btn_mode        (btn_mode),
        .pattern_select  (pattern_select),
        .frame_counter   (frame_counter),
        .auto_mode       (auto_mode),
        .pattern_changed (pattern_changed),
        .frame_tick      (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        pixel_x     = 10'd0;
        pixel_y     = 10'd0;
        btn_mode    = 1'b0;
        btn_next    = 1'b0;
        repeat (n) cyc();
    endtask

    // One 32-cycle frame; bit c of each mask is the raw button level during cycle c.
    task automatic run_frame(input logic step, input int hold,
                             input logic [31:0] mode_mask, input logic [31:0] next_mask);
        tick_q.push_back({exp_auto, exp_pat, exp_fc});
        exp_fc = exp_fc + 16'd64;
        if (step) begin
            exp_pat = exp_pat + 2'd1;
            chg_q.push_back(exp_pat);
        end
        for (int c = 0; c < 32; c++) begin
            pixel_x     = 10'(c % 8);
            pixel_y     = 10'(c / 8);
            pixel_valid = 1'b1;
            btn_mode    = mode_mask[c];
            btn_next    = next_mask[c];
            if (c == 31) repeat (hold) cyc();
            else cyc();
        end
    endtask

    // Two-cycle frame (one ordinary pixel, then the last pixel); never steps the pattern.
    task automatic fast_frame();
        tick_q.push_back({exp_auto, exp_pat, exp_fc});
        exp_fc      = exp_fc + 16'd64;
        pixel_valid = 1'b1;
        pixel_x     = 10'd0;
        pixel_y     = 10'd0;
        cyc();
        pixel_x     = 10'd7;
        pixel_y     = 10'd3;
        cyc();
    endtask

    // Monitor: compare every frame_tick and pattern_changed pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_tick === 1'b1) begin
                if (tick_q.size() == 0) begin
                    check("unexpected_frame_tick", 32'd1, 32'd0);
                end else begin
                    tick_e = tick_q.pop_front();
                    check("tick_frame_counter", 32'(frame_counter), 32'(tick_e[15:0]));
                    check("tick_pattern", 32'(pattern_select), 32'(tick_e[17:16]));
                    check("tick_auto_mode", 32'(auto_mode), 32'(tick_e[18]));
                end
            end
            if (pattern_changed === 1'b1) begin
                n_chg++;
                if (chg_q.size() == 0) begin
                    check("unexpected_pattern_changed", 32'd1, 32'd0);
                end else begin
                    chg_e = chg_q.pop_front();
                    check("changed_pattern", 32'(pattern_select), 32'(chg_e));
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        exp_fc   = 16'd0;
        exp_pat  = 2'd0;
        exp_auto = 1'b1;
        idle(3);
        rst_n = 1'b1;
        cyc();
        check("rst_pattern", 32'(pattern_select), 32'd0);
        check("rst_frame_counter", 32'(frame_counter), 32'd0);
        check("rst_auto_mode", 32'(auto_mode), 32'd1);
        check("rst_pattern_changed", 32'(pattern_changed), 32'd0);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);

        // Auto cycling: a step after frames 3, 6, 9 and 12.
        for (int f = 1; f <= 12; f++) run_frame((f % 3) == 0, 1, 32'd0, 32'd0);
        idle(2);
        check("auto_fc_768", 32'(frame_counter), 32'd768);
        check("auto_changes_4", 32'(n_chg), 32'd4);
        check("auto_pattern_wrap", 32'(pattern_select), 32'd0);

        // Last pixel held for 5 cycles: one tick, counter +64 (dwell now 1).
        run_frame(1'b0, 5, 32'd0, 32'd0);
        idle(2);
        check("hold_fc_832", 32'(frame_counter), 32'd832);

        // Clean mode press: manual exactly 7 edges after the raw rise.
        btn_mode = 1'b1;
        repeat (6) cyc();
        check("mode_latency_6", 32'(auto_mode), 32'd1);
        cyc();
        check("mode_latency_7", 32'(auto_mode), 32'd0);
        repeat (3) cyc();
        idle(8);
        exp_auto = 1'b0;
        for (int f = 0; f < 6; f++) run_frame(1'b0, 1, 32'd0, 32'd0);
        idle(2);
        check("manual_pattern_const", 32'(pattern_select), 32'd0);

        // Manual stepping: glitches ignored, single press, two presses in one frame, quiet frame.
        run_frame(1'b0, 1, 32'd0, 32'h0000_0033);
        run_frame(1'b1, 1, 32'd0, 32'h0003_FF00);
        run_frame(1'b1, 1, 32'd0, 32'h00FF_03FC);
        run_frame(1'b0, 1, 32'd0, 32'd0);
        idle(2);
        check("manual_pattern_2", 32'(pattern_select), 32'd2);

        // Mode and next together: back to auto, no step, then a step 3 ticks later.
        exp_auto = 1'b1;
        run_frame(1'b0, 1, 32'h0000_0FFC, 32'h0000_0FFC);
        run_frame(1'b0, 1, 32'd0, 32'd0);
        run_frame(1'b1, 1, 32'd0, 32'd0);
        idle(2);
        check("both_pattern_3", 32'(pattern_select), 32'd3);
        check("both_auto_mode", 32'(auto_mode), 32'd1);

        // Into manual, run up to 0xFFC0 and let the counter wrap.
        exp_auto = 1'b0;
        run_frame(1'b0, 1, 32'h0000_0FFC, 32'd0);
        n_fast = (16'hFFC0 - exp_fc) >> 6;
        for (int i = 0; i < int'(n_fast); i++) fast_frame();
        idle(2);
        check("fc_ffc0_a", 32'(frame_counter), 32'h0000_FFC0);
        run_frame(1'b0, 1, 32'd0, 32'd0);
        idle(2);
        check("fc_wrap_0000", 32'(frame_counter), 32'd0);

        // Back to 0xFFC0, set pending mid-frame, then a one-cycle reset.
        for (int i = 0; i < 1023; i++) fast_frame();
        idle(2);
        check("fc_ffc0_b", 32'(frame_counter), 32'h0000_FFC0);
        for (int c = 0; c < 16; c++) begin
            pixel_x     = 10'(c % 8);
            pixel_y     = 10'(c / 8);
            pixel_valid = 1'b1;
            btn_next    = (c < 10) ? 1'b1 : 1'b0;
            cyc();
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mid_rst_pattern", 32'(pattern_select), 32'd0);
        check("mid_rst_frame_counter", 32'(frame_counter), 32'd0);
        check("mid_rst_auto_mode", 32'(auto_mode), 32'd1);
        check("mid_rst_pattern_changed", 32'(pattern_changed), 32'd0);
        check("mid_rst_frame_tick", 32'(frame_tick), 32'd0);
        exp_fc   = 16'd0;
        exp_pat  = 2'd0;
        exp_auto = 1'b1;
        run_frame(1'b0, 1, 32'd0, 32'd0);
        idle(3);
        check("post_rst_fc_64", 32'(frame_counter), 32'd64);

        check("tick_queue_drained", 32'(tick_q.size()), 32'd0);
        check("changed_queue_drained", 32'(chg_q.size()), 32'd0);
        check("total_changes_7", 32'(n_chg), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
